// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction-store users.
// Holds the loader state encoding and the instruction word / pointer widths.
package prog_loader_pkg;

    localparam int unsigned INST_W = 20;
    localparam int unsigned IPTR_W = 9;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_B0     = 4'd3,
        S_B1     = 4'd4,
        S_B2     = 4'd5,
        S_CHK    = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } ld_state_e;

endpackage

// File: rtl/prog_word_asm.sv
// Instruction word assembler: captures B0/B1 of a word and combines them with
// the B2 byte currently on the stream.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   b0_we_i        capture data_i as B0
//   b1_we_i        capture data_i as B1
//   data_i         stream byte (B2 when the word is being completed)
//   word_c_o       {data_i[3:0], B1, B0}
//   nib_err_c_o    data_i[7:4] non-zero (illegal B2)
module prog_word_asm
    import prog_loader_pkg::*;
#(
    parameter int unsigned IW = INST_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          b0_we_i,
    input  logic          b1_we_i,
    input  logic [7:0]    data_i,
    output logic [IW-1:0] word_c_o,
    output logic          nib_err_c_o
);

    logic [7:0] b0_q;
    logic [7:0] b1_q;

    // Low bytes of the word under assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b0_q <= 8'h00;
            b1_q <= 8'h00;
        end else begin
            if (b0_we_i) b0_q <= data_i;
            if (b1_we_i) b1_q <= data_i;
        end
    end

    assign word_c_o    = IW'({data_i[3:0], b1_q, b0_q});
    assign nib_err_c_o = |data_i[7:4];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed byte stream, writes 20-bit
// words into instruction RAM and holds the core in reset until a frame with a
// correct checksum has been loaded.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 arms a load from IDLE/DONE/ERR
//   in_data/in_valid      stream byte and its valid
//   in_ready              registered; byte transfers when in_valid && in_ready
//   wr_en/wr_addr/wr_data instruction RAM write port
//   cpu_hold              1 keeps the core in reset
//   load_done / err       outcome of the last frame
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned IW    = INST_W,
    parameter int unsigned AW    = IPTR_W,
    parameter int unsigned DEPTH = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [IW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          err
);

    // One extra bit so a full DEPTH-word count does not wrap
    localparam int unsigned CW = AW + 1;

    ld_state_e     state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [IW-1:0] wr_data_q, wr_data_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          load_done_q, load_done_d;
    logic          err_q, err_d;
    logic [15:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    xor_q, xor_d;

    logic          xfer;
    logic          b0_we, b1_we;
    logic [IW-1:0] word_c;
    logic          nib_err_c;
    logic [15:0]   len_n;

    prog_word_asm #(.IW(IW)) u_word_asm (
        .clk         (clk),
        .reset       (reset),
        .b0_we_i     (b0_we),
        .b1_we_i     (b1_we),
        .data_i      (in_data),
        .word_c_o    (word_c),
        .nib_err_c_o (nib_err_c)
    );

    assign xfer = in_valid && in_ready_q;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= 16'h0000;
            cnt_q       <= '0;
            xor_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        err_d       = err_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        b0_we       = 1'b0;
        b1_we       = 1'b0;
        len_n       = {in_data, len_q[7:0]};

        // Checksum covers every frame byte before CHK
        if (xfer && state_q != S_CHK) begin
            xor_d = xor_q ^ in_data;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN_LO;
                    load_done_d = 1'b0;
                    err_d       = 1'b0;
                    cpu_hold_d  = 1'b1;
                    xor_d       = 8'h00;
                    cnt_d       = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (32'(len_n) > DEPTH) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else if (len_n == 16'h0000) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer) begin
                    b0_we   = 1'b1;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (xfer) begin
                    b1_we   = 1'b1;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    if (nib_err_c) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[AW-1:0];
                        wr_data_d = word_c;
                        cnt_d     = cnt_q + CW'(1);
                        state_d   = (16'(cnt_d) < len_q) ? S_B0 : S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == xor_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CHK waits until the last word's write strobe has gone out
        in_ready_d = (state_d inside {S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2}) ||
                     (state_d == S_CHK && !wr_en_d);
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are parsed by a byte-level model
// that predicts the written words, the number of bytes the loader accepts and
// the final outcome.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [19:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  frame[$];
    logic [19:0] exp_words[$];
    int          exp_consumed;
    bit          exp_ok;
    logic [28:0] cap_q[$];
    int          hold_viol = 0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; the core must be held whenever a write happens
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            cap_q.push_back({wr_addr, wr_data});
            if (cpu_hold !== 1'b1) hold_viol++;
        end
    end

    // Reference parser: walks the frame with the loader's accept/reject rules
    function automatic void model_frame();
        int n;
        int p;
        logic [7:0] x;
        logic [7:0] b0, b1, b2;
        exp_words.delete();
        exp_ok = 1'b0;
        n = int'({frame[1], frame[0]});
        x = frame[0] ^ frame[1];
        p = 2;
        if (n > 512) begin
            exp_consumed = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            b0 = frame[p];
            b1 = frame[p+1];
            b2 = frame[p+2];
            if (b2[7:4] != 4'h0) begin
                exp_consumed = p + 3;
                return;
            end
            exp_words.push_back({b2[3:0], b1, b0});
            x = x ^ b0 ^ b1 ^ b2;
            p = p + 3;
        end
        exp_consumed = p + 1;
        exp_ok = (frame[p] == x);
    endfunction

    // Random frame of n words; bad_idx >= 0 plants a non-zero upper nibble
    task automatic build_frame(input int n, input int bad_idx, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            frame.push_back(8'($urandom));
            frame.push_back(8'($urandom));
            b = {4'h0, 4'($urandom)};
            if (i == bad_idx) b[7:4] = 4'($urandom_range(15, 1));
            frame.push_back(b);
        end
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        if (bad_chk) x = x ^ 8'($urandom_range(255, 1));
        frame.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send the first cnt bytes of the frame; gap is the percent of idle cycles
    task automatic send_bytes(input int cnt, input int gap, input bit stray, output bit ok);
        int idx = 0;
        int cyc = 0;
        ok = 1'b1;
        while (idx < cnt) begin
            @(negedge clk);
            cyc++;
            if (cyc > cnt * 40 + 100) begin
                ok = 1'b0;
                break;
            end
            start    = stray && idx >= 3 && idx < 5;
            in_valid = ($urandom_range(99, 0) >= gap);
            in_data  = frame[idx];
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_frame(input string name, input int gap, input bit stray);
        bit ok;
        model_frame();
        cap_q.delete();
        // Bytes offered while not armed must not transfer
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        pulse_start();
        in_valid = 1'b0;
        send_bytes(exp_consumed, gap, stray, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s timeout: sent stalled, required %0d bytes accepted", name, exp_consumed);
        end
        n_cmp++;
        if (cap_q.size() !== exp_words.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, cap_q.size(), exp_words.size());
        end else begin
            foreach (exp_words[i]) begin
                n_cmp++;
                if (cap_q[i] !== {9'(i), exp_words[i]}) begin
                    n_bad++;
                    $display("FAIL %s write[%0d]: got addr %0d data %h required addr %0d data %h",
                             name, i, cap_q[i][28:20], cap_q[i][19:0], i, exp_words[i]);
                end
            end
        end
        n_cmp++;
        if ({load_done, err, cpu_hold, in_ready} !== {exp_ok, !exp_ok, !exp_ok, 1'b0}) begin
            n_bad++;
            $display("FAIL %s status: got done/err/hold/rdy %b%b%b%b required %b%b%b0",
                     name, load_done, err, cpu_hold, in_ready, exp_ok, !exp_ok, !exp_ok);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, err} !==
            {1'b0, 1'b0, 9'd0, 20'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got rdy %b wr_en %b addr %0d data %h hold %b done %b err %b required 0 0 0 0 1 0 0",
                     name, in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, err);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_known_frame();
        frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F, 8'h00};
        frame[8] = 8'h02 ^ 8'h34 ^ 8'h12 ^ 8'h05 ^ 8'hCD ^ 8'hAB ^ 8'h0F;
        run_frame("known_frame", 0, 1'b0);
        n_cmp++;
        if (cap_q.size() != 2 || cap_q[0] !== {9'd0, 20'h51234} || cap_q[1] !== {9'd1, 20'hFABCD}) begin
            n_bad++;
            $display("FAIL known_words: got %0d writes, required 0:51234 1:FABCD", cap_q.size());
        end
        frame[8] = 8'h00;
        run_frame("known_bad_chk", 0, 1'b0);
    endtask

    task automatic test_len_overflow();
        frame = '{8'h01, 8'h02, 8'h00};
        run_frame("len_513", 0, 1'b0);
        build_frame(512, -1, 1'b0);
        frame[1] = 8'h02;
        frame[0] = 8'h00;
        model_frame();
    endtask

    task automatic test_bad_nibble();
        build_frame(3, 1, 1'b0);
        frame[7] = 8'h15;
        run_frame("b2_nibble", 20, 1'b0);
    endtask

    task automatic test_zero_len();
        frame = '{8'h00, 8'h00, 8'h00};
        run_frame("len_zero", 0, 1'b0);
    endtask

    task automatic test_big_frame();
        build_frame(512, -1, 1'b0);
        run_frame("len_512_gaps", 50, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit ok;
        int wait_cyc = 0;
        build_frame(10, -1, 1'b0);
        cap_q.delete();
        pulse_start();
        send_bytes(11, 0, 1'b0, ok);
        while (cap_q.size() < 3 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (cap_q.size() !== 3 || !ok) begin
            n_bad++;
            $display("FAIL mid_reset_pre: got %0d writes required 3", cap_q.size());
        end
        #2 reset = 1'b1;
        #1 check_reset_values("mid_reset_async");
        @(negedge clk);
        reset = 1'b0;
        build_frame(1, -1, 1'b0);
        run_frame("after_reset", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(6, 1);
            build_frame(n, ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1,
                        $urandom_range(2, 0) == 0);
            run_frame($sformatf("b2b_%0d", k), (k % 2) * 30, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_len_overflow();
        test_bad_nibble();
        test_zero_len();
        test_big_frame();
        test_mid_reset();
        test_back_to_back();
        n_cmp++;
        if (hold_viol !== 0) begin
            n_bad++;
            $display("FAIL hold_during_write: got %0d writes with cpu_hold low required 0", hold_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
